// File: rtl/regs_wb_arbiter_pkg.sv
// Shared definitions for the register-bank writeback path.
//   WB_REG_AW / WB_REG_DW : register address / data width (16 x 8 bank)
//   WB_NUM_REGS           : number of architectural registers (scoreboard width)
//   WB_REQ_*              : writeback requester indices
//   rr_next()             : round-robin pointer successor
package regs_wb_arbiter_pkg;

    localparam int unsigned WB_REG_AW   = 4;
    localparam int unsigned WB_REG_DW   = 8;
    localparam int unsigned WB_NUM_REGS = 16;

    localparam int unsigned WB_REQ_ALU  = 0;
    localparam int unsigned WB_REQ_LD   = 1;
    localparam int unsigned WB_REQ_DBG  = 2;

    // Index following the granted one, wrapping at n-1.
    function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
        return (g + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: NREQ request lines -> one-hot grant.
// Search starts at the internal pointer and ascends, wrapping at NREQ-1.
// After a grant to index g the pointer moves to (g+1) mod NREQ; otherwise it holds.
//   clk, rst   : clock, synchronous active-high reset (pointer -> 0)
//   en         : grant enable; no grant and no pointer movement when low
//   req        : request vector
//   grant      : one-hot grant (at most one bit set)
//   grant_any  : some request was granted this cycle
//   grant_idx  : binary index of the granted request
module rr_arbiter
    import regs_wb_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  grant,
    output logic             grant_any,
    output logic [PTR_W-1:0] grant_idx
);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    int               idx;
    int unsigned      nxt;

    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = (int'(ptr_q) + k) % int'(NREQ);
            if (en && !grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_any  = 1'b1;
                grant_idx  = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        nxt   = rr_next(32'(grant_idx), NREQ);
        if (grant_any) begin
            ptr_d = nxt[PTR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Writeback arbiter for the 16x8 register bank.
// Shares the single bank write port among NREQ requesters (round-robin), registers the
// selected write into reg_write_*, and keeps a busy scoreboard for RAW-hazard stalls.
//   clk, rst              : clock, synchronous active-high reset
//   req_valid/addr/data   : per-requester write request, slices of REG_AW / REG_DW bits
//   req_ready             : one-hot grant; transfer happens when valid & ready
//   rsv_en, rsv_addr      : decode marks a destination register busy
//   flush                 : clears every busy bit (overrides a same-cycle reserve)
//   chk_addr_a/b, hazard_a/b : busy lookup for the two decode read ports
//   busy                  : registered scoreboard bitmap
//   reg_write_en/addr/data: registered write port into the register bank
module regs_wb_arbiter
    import regs_wb_arbiter_pkg::*;
#(
    parameter int unsigned NREQ   = 3,
    parameter int unsigned REG_AW = WB_REG_AW,
    parameter int unsigned REG_DW = WB_REG_DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*REG_AW-1:0]   req_addr,
    input  logic [NREQ*REG_DW-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     rsv_en,
    input  logic [REG_AW-1:0]        rsv_addr,
    input  logic                     flush,
    input  logic [REG_AW-1:0]        chk_addr_a,
    input  logic [REG_AW-1:0]        chk_addr_b,
    output logic                     hazard_a,
    output logic                     hazard_b,
    output logic [WB_NUM_REGS-1:0]   busy,
    output logic                     reg_write_en,
    output logic [REG_AW-1:0]        reg_write_addr,
    output logic [REG_DW-1:0]        reg_write_data
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        grant;
    logic                   grant_any;
    logic [PTR_W-1:0]       grant_idx;
    logic [REG_AW-1:0]      sel_addr;
    logic [REG_DW-1:0]      sel_data;
    logic [WB_NUM_REGS-1:0] busy_q, busy_d;

    // Grants are suppressed during reset so a write in flight is dropped.
    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .en        (!rst),
        .req       (req_valid),
        .grant     (grant),
        .grant_any (grant_any),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;

    always_comb begin
        sel_addr = req_addr[int'(grant_idx) * int'(REG_AW) +: REG_AW];
        sel_data = req_data[int'(grant_idx) * int'(REG_DW) +: REG_DW];
    end

    // Later assignments win: clear by writeback, then reserve, then flush.
    always_comb begin
        busy_d = busy_q;
        if (grant_any) begin
            busy_d[sel_addr] = 1'b0;
        end
        if (rsv_en) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q         <= '0;
            reg_write_en   <= 1'b0;
            reg_write_addr <= '0;
            reg_write_data <= '0;
        end else begin
            busy_q       <= busy_d;
            reg_write_en <= grant_any;
            if (grant_any) begin
                reg_write_addr <= sel_addr;
                reg_write_data <= sel_data;
            end
        end
    end

    assign busy = busy_q;

    // No bypass from this cycle's grant: decode sees the clear one cycle later.
    assign hazard_a = busy_q[chk_addr_a];
    assign hazard_b = busy_q[chk_addr_b];

endmodule

// File: tb/tb_regs_wb_arbiter.sv
module tb_regs_wb_arbiter;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [11:0] req_addr;
    logic [23:0] req_data;
    logic [2:0]  req_ready;
    logic        rsv_en;
    logic [3:0]  rsv_addr;
    logic        flush;
    logic [3:0]  chk_addr_a, chk_addr_b;
    logic        hazard_a, hazard_b;
    logic [15:0] busy;
    logic        reg_write_en;
    logic [3:0]  reg_write_addr;
    logic [7:0]  reg_write_data;

    int pass_cnt = 0;
    int total    = 0;
    int cur      = -1;

    logic [7:0] bank [16];

    regs_wb_arbiter #(
        .NREQ   (3),
        .REG_AW (4),
        .REG_DW (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .rsv_en         (rsv_en),
        .rsv_addr       (rsv_addr),
        .flush          (flush),
        .chk_addr_a     (chk_addr_a),
        .chk_addr_b     (chk_addr_b),
        .hazard_a       (hazard_a),
        .hazard_b       (hazard_b),
        .busy           (busy),
        .reg_write_en   (reg_write_en),
        .reg_write_addr (reg_write_addr),
        .reg_write_data (reg_write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register bank fed by the write port.
    always @(posedge clk) begin
        if (reg_write_en) bank[reg_write_addr] <= reg_write_data;
    end

    typedef struct {
        logic            rst;
        logic [2:0]      v;
        logic [2:0][3:0] a;
        logic [2:0][7:0] d;
        logic            rsv_en;
        logic [3:0]      rsv_addr;
        logic            flush;
        logic [3:0]      ca, cb;
        logic [2:0]      ready;
        logic            en;
        logic [3:0]      wa;
        logic [7:0]      wd;
        logic [15:0]     busy;
        logic            ha, hb;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(logic r, logic [2:0] v, logic [11:0] a, logic [23:0] d,
                                logic re, logic [3:0] ra, logic fl, logic [3:0] ca,
                                logic [3:0] cb, logic [2:0] rdy, logic en, logic [3:0] wa,
                                logic [7:0] wd, logic [15:0] bz, logic ha, logic hb);
        vec_t x;
        x.rst = r; x.v = v; x.a = a; x.d = d;
        x.rsv_en = re; x.rsv_addr = ra; x.flush = fl; x.ca = ca; x.cb = cb;
        x.ready = rdy; x.en = en; x.wa = wa; x.wd = wd; x.busy = bz; x.ha = ha; x.hb = hb;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s (vector %0d): got %h, expected %h", name, cur, act, exp);
    endtask

    logic [11:0] af;
    logic [23:0] df;

    initial begin
        af = {4'h6, 4'h2, 4'h1};
        df = {8'h66, 8'h22, 8'h11};
        //                 rst v     addr  data  rsv   ra    fl    ca    cb    rdy     en wa    wd     busy      ha hb
        vecs[0]  = mk(0, 3'b001, 12'h003, 24'h0000A5, 0, 4'h0, 0, 4'h0, 4'h0, 3'b001, 1, 4'h3, 8'hA5, 16'h0000, 0, 0);
        vecs[1]  = mk(0, 3'b000, 12'h003, 24'h0000A5, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0, 4'h3, 8'hA5, 16'h0000, 0, 0);
        vecs[2]  = mk(1, 3'b111, af,      df,         0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0, 4'h0, 8'h00, 16'h0000, 0, 0);
        vecs[3]  = mk(0, 3'b111, af,      df,         0, 4'h0, 0, 4'h0, 4'h0, 3'b001, 1, 4'h1, 8'h11, 16'h0000, 0, 0);
        vecs[4]  = mk(0, 3'b111, af,      df,         0, 4'h0, 0, 4'h0, 4'h0, 3'b010, 1, 4'h2, 8'h22, 16'h0000, 0, 0);
        vecs[5]  = mk(0, 3'b111, af,      df,         0, 4'h0, 0, 4'h0, 4'h0, 3'b100, 1, 4'h6, 8'h66, 16'h0000, 0, 0);
        vecs[6]  = mk(0, 3'b111, af,      df,         0, 4'h0, 0, 4'h0, 4'h0, 3'b001, 1, 4'h1, 8'h11, 16'h0000, 0, 0);
        vecs[7]  = mk(0, 3'b111, af,      df,         0, 4'h0, 0, 4'h0, 4'h0, 3'b010, 1, 4'h2, 8'h22, 16'h0000, 0, 0);
        vecs[8]  = mk(0, 3'b101, af,      df,         0, 4'h0, 0, 4'h0, 4'h0, 3'b100, 1, 4'h6, 8'h66, 16'h0000, 0, 0);
        vecs[9]  = mk(0, 3'b101, af,      df,         0, 4'h0, 0, 4'h0, 4'h0, 3'b001, 1, 4'h1, 8'h11, 16'h0000, 0, 0);
        vecs[10] = mk(0, 3'b101, af,      df,         0, 4'h0, 0, 4'h0, 4'h0, 3'b100, 1, 4'h6, 8'h66, 16'h0000, 0, 0);
        vecs[11] = mk(0, 3'b101, af,      df,         0, 4'h0, 0, 4'h0, 4'h0, 3'b001, 1, 4'h1, 8'h11, 16'h0000, 0, 0);
        vecs[12] = mk(0, 3'b000, af,      df,         1, 4'h5, 0, 4'h5, 4'h0, 3'b000, 0, 4'h1, 8'h11, 16'h0020, 0, 0);
        vecs[13] = mk(0, 3'b010, 12'h050, 24'h005A00, 0, 4'h0, 0, 4'h5, 4'h5, 3'b010, 1, 4'h5, 8'h5A, 16'h0000, 1, 1);
        vecs[14] = mk(0, 3'b000, 12'h050, 24'h005A00, 0, 4'h0, 0, 4'h5, 4'h0, 3'b000, 0, 4'h5, 8'h5A, 16'h0000, 0, 0);
        vecs[15] = mk(0, 3'b001, 12'h007, 24'h000077, 1, 4'h7, 0, 4'h0, 4'h0, 3'b001, 1, 4'h7, 8'h77, 16'h0080, 0, 0);
        vecs[16] = mk(0, 3'b001, 12'h007, 24'h000078, 1, 4'h7, 1, 4'h7, 4'h0, 3'b001, 1, 4'h7, 8'h78, 16'h0000, 1, 0);
        vecs[17] = mk(0, 3'b000, 12'h007, 24'h000078, 1, 4'h2, 0, 4'h0, 4'h0, 3'b000, 0, 4'h7, 8'h78, 16'h0004, 0, 0);
        vecs[18] = mk(0, 3'b000, 12'h007, 24'h000078, 1, 4'h9, 0, 4'h2, 4'h9, 3'b000, 0, 4'h7, 8'h78, 16'h0204, 1, 0);
        vecs[19] = mk(0, 3'b000, 12'h007, 24'h000078, 1, 4'h3, 1, 4'h9, 4'h2, 3'b000, 0, 4'h7, 8'h78, 16'h0000, 1, 1);
        vecs[20] = mk(0, 3'b111, af,      df,         1, 4'h4, 0, 4'h4, 4'h0, 3'b010, 1, 4'h2, 8'h22, 16'h0010, 0, 0);
        vecs[21] = mk(1, 3'b111, af,      df,         1, 4'h4, 0, 4'h4, 4'h0, 3'b000, 0, 4'h0, 8'h00, 16'h0000, 1, 0);
        vecs[22] = mk(0, 3'b111, af,      df,         0, 4'h0, 0, 4'h4, 4'h0, 3'b001, 1, 4'h1, 8'h11, 16'h0000, 0, 0);
        vecs[23] = mk(0, 3'b000, af,      df,         0, 4'h0, 0, 4'h0, 4'h0, 3'b000, 0, 4'h1, 8'h11, 16'h0000, 0, 0);

        // Reset held two cycles with every requester valid.
        rst = 1'b1; req_valid = 3'b111; req_addr = af; req_data = df;
        rsv_en = 1'b0; rsv_addr = 4'h0; flush = 1'b0; chk_addr_a = 4'h0; chk_addr_b = 4'h0;
        @(posedge clk);
        #1 chk("reset_ready", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("reset_ready2", 32'(req_ready), 32'h0);
        chk("reset_en", 32'(reg_write_en), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_waddr", 32'(reg_write_addr), 32'h0);
        chk("reset_wdata", 32'(reg_write_data), 32'h0);

        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            cur        = i;
            rst        = vecs[i].rst;
            req_valid  = vecs[i].v;
            req_addr   = vecs[i].a;
            req_data   = vecs[i].d;
            rsv_en     = vecs[i].rsv_en;
            rsv_addr   = vecs[i].rsv_addr;
            flush      = vecs[i].flush;
            chk_addr_a = vecs[i].ca;
            chk_addr_b = vecs[i].cb;
            #1;
            chk("req_ready", 32'(req_ready), 32'(vecs[i].ready));
            chk("hazard_a", 32'(hazard_a), 32'(vecs[i].ha));
            chk("hazard_b", 32'(hazard_b), 32'(vecs[i].hb));
            @(posedge clk);
            #1;
            chk("reg_write_en", 32'(reg_write_en), 32'(vecs[i].en));
            chk("reg_write_addr", 32'(reg_write_addr), 32'(vecs[i].wa));
            chk("reg_write_data", 32'(reg_write_data), 32'(vecs[i].wd));
            chk("busy", 32'(busy), 32'(vecs[i].busy));
            @(negedge clk);
        end

        // Bank contents after the sequence: r3 from the first ALU write, r5 from the
        // load, r7 from the later of two back-to-back writes.
        cur = -1;
        chk("bank_r3", 32'(bank[3]), 32'hA5);
        chk("bank_r5", 32'(bank[5]), 32'h5A);
        chk("bank_r7", 32'(bank[7]), 32'h78);
        chk("bank_r6", 32'(bank[6]), 32'h66);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
